// File: rtl/q_meter.sv
// Q measurement front end: settle the bias, excite the resonator, then count
// synchronized oscillation edges while the envelope stays above threshold.
module q_meter #(
  parameter int BUS_WIDTH      = 10,
  parameter int SETTLE_CYCLES  = 64,
  parameter int EXCITE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 osc_in,
  input  logic                 env_in,
  output logic                 excite,
  output logic                 busy,
  output logic                 ready,
  output logic                 timeout,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_EXCITE = 3'd2,
    S_ARM    = 3'd3,
    S_COUNT  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EW = (EXCITE_CYCLES > 1) ? $clog2(EXCITE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [EW-1:0]      EXCITE_LOAD = EW'(EXCITE_CYCLES - 1);
  localparam logic [TW-1:0]      TMO_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BUS_WIDTH:0] EDGE_MAX    = {1'b0, {BUS_WIDTH{1'b1}}};

  state_t               state;
  state_t               state_nx;
  logic [SW-1:0]        settle_cnt;
  logic [EW-1:0]        excite_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [BUS_WIDTH:0]   edge_cnt;
  logic                 osc_meta;
  logic                 osc_s;
  logic                 osc_d;
  logic                 env_meta;
  logic                 env_s;
  logic                 osc_rise;
  logic                 tmo_flag;
  logic                 tmo_hit;

  assign osc_rise  = osc_s & ~osc_d;
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    if (!enable && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable && start) state_nx = S_SETTLE;
        S_SETTLE: if (settle_cnt == '0) state_nx = S_EXCITE;
        S_EXCITE: if (excite_cnt == '0) state_nx = S_ARM;
        S_ARM: begin
          if (tmo_cnt == '0) begin
            state_nx = S_DONE;
            tmo_hit  = 1'b1;
          end else if (env_s) begin
            state_nx = S_COUNT;
          end
        end
        // An envelope drop wins over a coincident timeout: the ring decayed normally.
        S_COUNT: begin
          if (!env_s) begin
            state_nx = S_DONE;
          end else if (tmo_cnt == '0) begin
            state_nx = S_DONE;
            tmo_hit  = 1'b1;
          end
        end
        S_DONE:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // ready is a one-cycle valid strobe for q_measured; there is no backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      excite_cnt <= '0;
      tmo_cnt    <= '0;
      edge_cnt   <= '0;
      osc_meta   <= 1'b0;
      osc_s      <= 1'b0;
      osc_d      <= 1'b0;
      env_meta   <= 1'b0;
      env_s      <= 1'b0;
      tmo_flag   <= 1'b0;
      excite     <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      timeout    <= 1'b0;
      q_measured <= '0;
    end else begin
      state    <= state_nx;
      osc_meta <= osc_in;
      osc_s    <= osc_meta;
      osc_d    <= osc_s;
      env_meta <= env_in;
      env_s    <= env_meta;

      busy   <= (state != S_IDLE);
      excite <= (state == S_EXCITE) && enable;
      ready  <= (state == S_DONE) && enable;

      if ((state == S_IDLE) && (state_nx == S_SETTLE)) begin
        settle_cnt <= SETTLE_LOAD;
        timeout    <= 1'b0;
      end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SW'(1);
      end

      if ((state == S_SETTLE) && (state_nx == S_EXCITE)) begin
        excite_cnt <= EXCITE_LOAD;
        edge_cnt   <= '0;
        tmo_flag   <= 1'b0;
      end else if ((state == S_EXCITE) && (excite_cnt != '0)) begin
        excite_cnt <= excite_cnt - EW'(1);
      end

      if ((state == S_EXCITE) && (state_nx == S_ARM)) begin
        tmo_cnt <= TMO_LOAD;
      end else if (((state == S_ARM) || (state == S_COUNT)) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end

      // A timeout while counting means the envelope never decayed: report full scale.
      if (state == S_COUNT) begin
        if (tmo_hit) begin
          edge_cnt <= EDGE_MAX;
        end else if (osc_rise && (edge_cnt < EDGE_MAX)) begin
          edge_cnt <= edge_cnt + (BUS_WIDTH + 1)'(1);
        end
      end

      if (tmo_hit) tmo_flag <= 1'b1;

      if ((state == S_DONE) && enable) begin
        q_measured <= (edge_cnt > EDGE_MAX) ? {BUS_WIDTH{1'b1}} : edge_cnt[BUS_WIDTH-1:0];
        timeout    <= tmo_flag;
      end
    end
  end

endmodule

// File: tb/tb_q_meter.sv
// Bench for q_meter: two instances (10-bit / 200-cycle timeout and 4-bit /
// 100-cycle timeout) share one stimulus and are tracked by an elapsed-time model.
module tb_q_meter;

  localparam int S_C   = 4;
  localparam int E_C   = 2;
  localparam int T_A   = 200;
  localparam int T_B   = 100;
  localparam int MAX_A = 1023;
  localparam int MAX_B = 15;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic       osc_in;
  logic       env_in;
  logic       excite_a, busy_a, ready_a, timeout_a;
  logic       excite_b, busy_b, ready_b, timeout_b;
  logic [9:0] q_a;
  logic [3:0] q_b;
  logic [2:0] state_a, state_b;

  q_meter #(.BUS_WIDTH(10), .SETTLE_CYCLES(S_C), .EXCITE_CYCLES(E_C), .TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .osc_in(osc_in), .env_in(env_in),
    .excite(excite_a), .busy(busy_a), .ready(ready_a), .timeout(timeout_a),
    .q_measured(q_a), .state_dbg(state_a)
  );

  q_meter #(.BUS_WIDTH(4), .SETTLE_CYCLES(S_C), .EXCITE_CYCLES(E_C), .TIMEOUT_CYCLES(T_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .osc_in(osc_in), .env_in(env_in),
    .excite(excite_b), .busy(busy_b), .ready(ready_b), .timeout(timeout_b),
    .q_measured(q_b), .state_dbg(state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int rdy_a_n  = 0;
  int rdy_b_n  = 0;

  task automatic check(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: a measurement is a timeline measured in cycles since acceptance.
  typedef struct {
    bit act;
    int el;
    bit cnt_on;
    bit fin;
    int edges;
    int res;
    bit tmo_pend;
    bit e1, e2, o1, o2, o3;
    bit excite, busy, ready, tmo;
    int q;
  } m_t;

  m_t ma = '{default: 0};
  m_t mb = '{default: 0};

  function automatic m_t model_step(input m_t m, input int t_c, input int q_max,
                                    input bit r, input bit en, input bit st,
                                    input bit os, input bit ev);
    m_t n;
    bit env_now;
    bit rise;
    int w;
    n = m;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    env_now = m.e2;
    rise    = m.o2 && !m.o3;
    n.e1 = ev; n.e2 = m.e1;
    n.o1 = os; n.o2 = m.o1; n.o3 = m.o2;
    n.busy   = m.act;
    n.excite = m.act && !m.fin && (m.el >= S_C) && (m.el < S_C + E_C) && en;
    n.ready  = 1'b0;
    if (!m.act) begin
      if (en && st) begin
        n.act = 1; n.el = 0; n.cnt_on = 0; n.fin = 0;
        n.edges = 0; n.res = 0; n.tmo_pend = 0; n.tmo = 0;
      end
    end else if (!en) begin
      n.act = 0;
    end else if (m.fin) begin
      n.act = 0; n.fin = 0; n.ready = 1; n.q = m.res; n.tmo = m.tmo_pend;
    end else begin
      n.el = m.el + 1;
      if (m.el >= S_C + E_C) begin
        w = m.el - S_C - E_C;
        if (!m.cnt_on) begin
          if (w == t_c - 1) begin
            n.fin = 1; n.res = 0; n.tmo_pend = 1;
          end else if (env_now) begin
            n.cnt_on = 1;
          end
        end else begin
          if (rise && m.edges < q_max) n.edges = m.edges + 1;
          if (!env_now) begin
            n.fin = 1; n.res = n.edges; n.tmo_pend = 0;
          end else if (w == t_c - 1) begin
            n.fin = 1; n.res = q_max; n.tmo_pend = 1;
          end
        end
      end
    end
    return n;
  endfunction

  // scoreboard: every cycle, both instances against the model
  always @(posedge clk) begin
    #1;
    cyc++;
    ma = model_step(ma, T_A, MAX_A, rst_n, enable, start, osc_in, env_in);
    mb = model_step(mb, T_B, MAX_B, rst_n, enable, start, osc_in, env_in);
    if (cyc > 1) begin
      check("a_excite", int'(excite_a), int'(ma.excite));
      check("a_busy", int'(busy_a), int'(ma.busy));
      check("a_ready", int'(ready_a), int'(ma.ready));
      check("a_timeout", int'(timeout_a), int'(ma.tmo));
      check("a_q", int'(q_a), ma.q);
      check("b_excite", int'(excite_b), int'(mb.excite));
      check("b_busy", int'(busy_b), int'(mb.busy));
      check("b_ready", int'(ready_b), int'(mb.ready));
      check("b_timeout", int'(timeout_b), int'(mb.tmo));
      check("b_q", int'(q_b), mb.q);
    end
    if (ready_a === 1'b1) rdy_a_n++;
    if (ready_b === 1'b1) rdy_b_n++;
  end

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic osc_burst(input int n);
    repeat (n) begin
      osc_in = 1'b1; tick(2);
      osc_in = 1'b0; tick(2);
    end
  endtask

  task automatic run_meas(input int edges);
    start = 1'b1; tick(1);
    start = 1'b0; tick(9);
    env_in = 1'b1; tick(2);
    osc_burst(edges);
    env_in = 1'b0; tick(15);
  endtask

  int ra0, rb0;
  bit found;

  initial begin
    rst_n = 1'b0; enable = 1'b1; start = 1'b1; osc_in = 1'b0; env_in = 1'b0;

    // reset held with start/enable high
    tick(3);
    check("rst_busy", int'(busy_a), 0);
    check("rst_excite", int'(excite_a), 0);
    check("rst_ready", int'(ready_a), 0);
    check("rst_timeout", int'(timeout_a), 0);
    check("rst_q", int'(q_a), 0);
    rst_n = 1'b1;
    tick(1);
    check("busy_after_1st_edge", int'(busy_a), 0);
    start = 1'b0;
    tick(1);
    check("busy_after_2nd_edge", int'(busy_a), 1);

    // envelope never rises: timeout with zero result
    ra0 = rdy_a_n; rb0 = rdy_b_n;
    tick(230);
    check("noring_a_q", int'(q_a), 0);
    check("noring_a_timeout", int'(timeout_a), 1);
    check("noring_b_q", int'(q_b), 0);
    check("noring_b_timeout", int'(timeout_b), 1);
    check("noring_ready_count", rdy_a_n - ra0 + rdy_b_n - rb0, 2);

    // nominal: excite timing, then 37 edges
    ra0 = rdy_a_n; rb0 = rdy_b_n;
    start = 1'b1; tick(1);
    start = 1'b0;
    check("start_clears_timeout", int'(timeout_a), 0);
    tick(4);
    check("excite_pre", int'(excite_a), 0);
    tick(1);
    check("excite_first", int'(excite_a), 1);
    tick(1);
    check("excite_second", int'(excite_a), 1);
    tick(1);
    check("excite_end", int'(excite_a), 0);
    tick(3);
    env_in = 1'b1; tick(2);
    osc_burst(37);
    env_in = 1'b0; tick(15);
    check("nominal_a_q", int'(q_a), 37);
    check("nominal_a_timeout", int'(timeout_a), 0);
    check("nominal_a_busy", int'(busy_a), 0);
    check("nominal_a_ready_count", rdy_a_n - ra0, 1);
    check("nominal_b_q", int'(q_b), 15);
    check("nominal_b_timeout", int'(timeout_b), 1);

    // saturation of the 4-bit instance within its window
    run_meas(20);
    check("sat_a_q", int'(q_a), 20);
    check("sat_b_q", int'(q_b), 15);
    check("sat_b_timeout", int'(timeout_b), 0);

    // envelope stuck high with edges
    start = 1'b1; tick(1);
    start = 1'b0; tick(9);
    env_in = 1'b1;
    osc_burst(60);
    env_in = 1'b0; tick(10);
    check("stuck_a_q", int'(q_a), 1023);
    check("stuck_a_timeout", int'(timeout_a), 1);
    check("stuck_b_q", int'(q_b), 15);
    check("stuck_b_timeout", int'(timeout_b), 1);

    // abort mid-count
    ra0 = rdy_a_n; rb0 = rdy_b_n;
    start = 1'b1; tick(1);
    start = 1'b0; tick(9);
    env_in = 1'b1; tick(2);
    osc_burst(10);
    enable = 1'b0; tick(3);
    check("abort_excite", int'(excite_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_state_idle", int'(state_a), 0);
    check("abort_a_q_held", int'(q_a), 1023);
    check("abort_b_q_held", int'(q_b), 15);
    check("abort_timeout_cleared", int'(timeout_a), 0);
    check("abort_no_ready", rdy_a_n - ra0 + rdy_b_n - rb0, 0);
    env_in = 1'b0; enable = 1'b1; tick(5);

    // synchronous reset during excitation, then a fresh measurement
    start = 1'b1; tick(1);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (excite_a === 1'b1) found = 1'b1;
    end
    check("reset_wait_excite", int'(found), 1);
    rst_n = 1'b0; tick(1);
    check("reset_excite_low", int'(excite_a), 0);
    check("reset_q_cleared", int'(q_a), 0);
    rst_n = 1'b1; tick(2);
    run_meas(12);
    check("post_reset_a_q", int'(q_a), 12);
    check("post_reset_b_q", int'(q_b), 12);
    check("post_reset_timeout", int'(timeout_a), 0);

    tick(5);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
